// File: rtl/k005297_sertimer.sv
// -----------------------------------------------------------------------------
// k005297_sertimer
//
// Bit-serial up-timer for the K005297 bubble-memory controller timing section.
// A WIDTH-bit count register circulates LSB-first through a one-bit serial
// full adder, one bit per enabled MCLK cycle (a "slot"). WIDTH slots make one
// frame, and each frame produces one new count value. While the new value is
// being written it is compared bit-by-bit against a shadow copy of the limit.
// The timer can run one-shot (sticky time-over, count holds) or auto-reload
// (periodic, the frame after a match writes 0).
//
// Parameters
//   WIDTH          count / limit width, frame length in enabled cycles (2..32)
//   SNAP_ON_MATCH  1 = o_COUNT also loads on every match frame
//
// Ports
//   i_MCLK         master clock, all state changes on the rising edge
//   i_RST          asynchronous active-high reset
//   i_CEN_n        active-low clock enable, one enabled cycle = one bit slot
//   i_CNT          increment request for the frame (sampled at slot 0)
//   i_CLR          synchronous clear for the frame (sampled at slot 0)
//   i_AUTORELOAD   0 = one-shot, 1 = periodic (sampled at slot 0)
//   i_LIMIT        compare value (captured into a shadow register at slot 0)
//   i_SNAP_LD_n    active-low snapshot request, sampled on any enabled cycle
//   o_FRAME_START  high during enabled cycles at slot 0
//   o_TIMEOVER_n   active-low time-over indication
//   o_MATCH        one-MCLK pulse on the frame-end edge that wrote the limit
//   o_WRAP         one-MCLK pulse on the frame-end edge that wrapped to 0
//   o_COUNT        frame-coherent snapshot of the count register
// -----------------------------------------------------------------------------
module k005297_sertimer #(
   parameter int WIDTH         = 12,
   parameter bit SNAP_ON_MATCH = 1'b0
) (
   input  logic             i_MCLK,
   input  logic             i_RST,
   input  logic             i_CEN_n,
   input  logic             i_CNT,
   input  logic             i_CLR,
   input  logic             i_AUTORELOAD,
   input  logic [WIDTH-1:0] i_LIMIT,
   input  logic             i_SNAP_LD_n,
   output logic             o_FRAME_START,
   output logic             o_TIMEOVER_n,
   output logic             o_MATCH,
   output logic             o_WRAP,
   output logic [WIDTH-1:0] o_COUNT
);

   localparam int            SW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [SW-1:0] LAST_SLOT = SW'(WIDTH - 1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [SW-1:0]    slot;          // bit position currently at count_sr[0]
   logic [WIDTH-1:0] count_sr;      // circulating count, LSB leaves first
   logic             carry;         // serial adder carry between slots
   logic             eq_flag;       // running "written bits == limit bits"
   logic             sticky;        // one-shot time-over latch
   logic             match_prev;    // previous frame ended in a match
   logic             snap_pending;  // snapshot requested earlier in the frame

   // Frame controls captured at slot 0 and held for the rest of the frame.
   logic             cnt_q;
   logic             clr_q;
   logic             autoreload_q;
   logic [WIDTH-1:0] limit_q;

   // ---------------------------------------------------------------------------
   // Combinational datapath
   // ---------------------------------------------------------------------------
   logic             en;
   logic             first_slot;
   logic             last_slot;
   logic             cnt_f;
   logic             clr_f;
   logic             autoreload_f;
   logic [WIDTH-1:0] limit_f;
   logic             inhibit;
   logic             inc;
   logic             cin;
   logic             clr_frame;
   logic             sum;
   logic             cout;
   logic             wr_bit;
   logic             eq_next;
   logic             match_now;
   logic             sticky_next;
   logic             snap_load;
   logic [WIDTH-1:0] new_value;

   // NOTE: every signal below is assigned on every pass through the block, so
   // no path leaves a value unassigned and no latch can be inferred.
   always_comb begin
      en         = ~i_CEN_n;
      first_slot = (slot == '0);
      last_slot  = (slot == LAST_SLOT);

      // Slot 0 uses the live inputs so the controls apply to the whole frame,
      // including the slot in which they are captured.
      cnt_f        = first_slot ? i_CNT        : cnt_q;
      clr_f        = first_slot ? i_CLR        : clr_q;
      autoreload_f = first_slot ? i_AUTORELOAD : autoreload_q;
      limit_f      = first_slot ? i_LIMIT      : limit_q;

      // A one-shot timer that has already timed out holds its value.
      inhibit   = ~autoreload_f & sticky;
      inc       = cnt_f & ~inhibit;
      cin       = first_slot & inc;

      // Reload-clear: in periodic mode the frame after a match writes 0.
      clr_frame = clr_f | (autoreload_f & match_prev);

      sum    = count_sr[0] ^ carry ^ cin;
      cout   = (count_sr[0] & carry) | (count_sr[0] & cin) | (carry & cin);
      wr_bit = sum & ~clr_frame;

      // The compare runs on the bit actually written, so clears and holds are
      // compared just like ordinary increments.
      eq_next   = (first_slot ? 1'b1 : eq_flag) & (wr_bit == limit_f[slot]);
      match_now = last_slot & eq_next;

      // Sticky is only meaningful in one-shot mode; periodic mode signals
      // time-over from the match itself, for exactly one frame.
      sticky_next = ~autoreload_f & (match_now | (sticky & ~clr_f));

      // Value the register will hold once this slot's bit is shifted in; at
      // the last slot this is the complete, coherent new count.
      new_value = {wr_bit, count_sr[WIDTH-1:1]};

      snap_load = snap_pending | ~i_SNAP_LD_n | (SNAP_ON_MATCH & match_now);
   end

   assign o_FRAME_START = en & first_slot;

   // ---------------------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments so every register
   // samples the values from before this edge, independent of statement order.
   always_ff @(posedge i_MCLK or posedge i_RST) begin
      if (i_RST) begin
         slot         <= '0;
         count_sr     <= '0;
         carry        <= 1'b0;
         eq_flag      <= 1'b1;
         sticky       <= 1'b0;
         match_prev   <= 1'b0;
         snap_pending <= 1'b0;
         cnt_q        <= 1'b0;
         clr_q        <= 1'b0;
         autoreload_q <= 1'b0;
         limit_q      <= '0;
         o_COUNT      <= '0;
         o_TIMEOVER_n <= 1'b1;
         o_MATCH      <= 1'b0;
         o_WRAP       <= 1'b0;
      end else begin
         // Pulses last one MCLK regardless of the enable.
         o_MATCH <= 1'b0;
         o_WRAP  <= 1'b0;

         if (en) begin
            slot     <= last_slot ? '0 : slot + 1'b1;
            count_sr <= new_value;
            eq_flag  <= eq_next;
            // Carry must not leak into the next frame's LSB.
            carry    <= last_slot ? 1'b0 : cout;

            if (first_slot) begin
               cnt_q        <= i_CNT;
               clr_q        <= i_CLR;
               autoreload_q <= i_AUTORELOAD;
               limit_q      <= i_LIMIT;
            end

            if (last_slot) begin
               o_MATCH      <= match_now;
               o_WRAP       <= cout & ~clr_frame;
               match_prev   <= match_now;
               sticky       <= sticky_next;
               o_TIMEOVER_n <= ~(match_now | sticky_next);
               if (snap_load) begin
                  o_COUNT <= new_value;
               end
               snap_pending <= 1'b0;
            end else if (!i_SNAP_LD_n) begin
               snap_pending <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_k005297_sertimer.sv
// -----------------------------------------------------------------------------
// tb_k005297_sertimer
//
// Self-checking bench for k005297_sertimer (WIDTH=8, SNAP_ON_MATCH=0).
// A frame-level arithmetic model tracks the expected outputs; one compare
// process checks every DUT output against it on each falling MCLK edge.
// Directed phases pin the model with hand-computed values (one-shot hold,
// periodic reload, wrap, snapshot coherence, clear priority, async reset),
// followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_k005297_sertimer;

   localparam int W = 8;

   logic         i_MCLK;
   logic         i_RST;
   logic         i_CEN_n;
   logic         i_CNT;
   logic         i_CLR;
   logic         i_AUTORELOAD;
   logic [W-1:0] i_LIMIT;
   logic         i_SNAP_LD_n;
   logic         o_FRAME_START;
   logic         o_TIMEOVER_n;
   logic         o_MATCH;
   logic         o_WRAP;
   logic [W-1:0] o_COUNT;

   k005297_sertimer #(
      .WIDTH         (W),
      .SNAP_ON_MATCH (1'b0)
   ) dut (
      .i_MCLK        (i_MCLK),
      .i_RST         (i_RST),
      .i_CEN_n       (i_CEN_n),
      .i_CNT         (i_CNT),
      .i_CLR         (i_CLR),
      .i_AUTORELOAD  (i_AUTORELOAD),
      .i_LIMIT       (i_LIMIT),
      .i_SNAP_LD_n   (i_SNAP_LD_n),
      .o_FRAME_START (o_FRAME_START),
      .o_TIMEOVER_n  (o_TIMEOVER_n),
      .o_MATCH       (o_MATCH),
      .o_WRAP        (o_WRAP),
      .o_COUNT       (o_COUNT)
   );

   initial begin
      i_MCLK = 1'b0;
      forever #5 i_MCLK = ~i_MCLK;
   end

   // ---------------------------------------------------------------------------
   // Bookkeeping
   // ---------------------------------------------------------------------------
   int tests = 0;
   int fails = 0;
   int n_match_seen = 0;
   int n_wrap_seen  = 0;

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Frame-level reference model
   // ---------------------------------------------------------------------------
   int           m_slot;
   logic [W-1:0] m_count;
   bit           m_sticky;
   bit           m_match_prev;
   bit           m_pending;
   bit           m_tov_n;
   bit           m_match;
   bit           m_wrap;
   logic [W-1:0] m_ocount;
   bit           f_cnt;
   bit           f_clr;
   bit           f_ar;
   logic [W-1:0] f_lim;

   task automatic m_reset();
      m_slot       = 0;
      m_count      = '0;
      m_sticky     = 1'b0;
      m_match_prev = 1'b0;
      m_pending    = 1'b0;
      m_tov_n      = 1'b1;
      m_match      = 1'b0;
      m_wrap       = 1'b0;
      m_ocount     = '0;
      f_cnt        = 1'b0;
      f_clr        = 1'b0;
      f_ar         = 1'b0;
      f_lim        = '0;
   endtask

   // Whole-frame result: new = clear ? 0 : (count + inc) mod 2^W.
   task automatic m_frame_end();
      bit           inc;
      bit           clrf;
      bit           hit;
      int           total;
      logic [W-1:0] nv;
      inc   = f_cnt && !(!f_ar && m_sticky);
      clrf  = f_clr || (f_ar && m_match_prev);
      total = int'(m_count) + (inc ? 1 : 0);
      nv    = clrf ? '0 : W'(total);
      hit   = (nv == f_lim);
      m_match = hit;
      m_wrap  = !clrf && (total == (1 << W));
      if (f_ar)       m_sticky = 1'b0;
      else if (hit)   m_sticky = 1'b1;
      else if (f_clr) m_sticky = 1'b0;
      m_tov_n = !(hit || m_sticky);
      if (m_pending || !i_SNAP_LD_n) m_ocount = nv;
      m_pending    = 1'b0;
      m_count      = nv;
      m_match_prev = hit;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge i_MCLK or posedge i_RST);
         if (i_RST) begin
            m_reset();
         end else begin
            m_match = 1'b0;
            m_wrap  = 1'b0;
            if (!i_CEN_n) begin
               if (m_slot == 0) begin
                  f_cnt = i_CNT;
                  f_clr = i_CLR;
                  f_ar  = i_AUTORELOAD;
                  f_lim = i_LIMIT;
               end
               if (m_slot == W - 1) m_frame_end();
               else if (!i_SNAP_LD_n) m_pending = 1'b1;
               m_slot = (m_slot + 1) % W;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Compare process: every falling edge, away from the active edge
   // ---------------------------------------------------------------------------
   initial begin
      forever begin
         @(negedge i_MCLK);
         check("frame_start", 32'(o_FRAME_START), 32'(!i_CEN_n && (m_slot == 0)));
         check("timeover_n",  32'(o_TIMEOVER_n),  32'(m_tov_n));
         check("match",       32'(o_MATCH),       32'(m_match));
         check("wrap",        32'(o_WRAP),        32'(m_wrap));
         check("count",       32'(o_COUNT),       32'(m_ocount));
         if (o_MATCH === 1'b1) n_match_seen++;
         if (o_WRAP  === 1'b1) n_wrap_seen++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (called at posedge+2; return at posedge+2)
   // ---------------------------------------------------------------------------
   task automatic slot_cycle(input bit gap);
      i_CEN_n = 1'b0;
      @(posedge i_MCLK); #2;
      if (gap) begin
         i_CEN_n = 1'b1;
         @(posedge i_MCLK); #2;
      end
   endtask

   task automatic run_frames(input int n, input bit gap, input bit snap_n);
      for (int f = 0; f < n; f++) begin
         for (int s = 0; s < W; s++) begin
            i_SNAP_LD_n = snap_n;
            slot_cycle(gap);
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   int match_base;
   int wrap_base;

   initial begin
      i_RST        = 1'b1;
      i_CEN_n      = 1'b1;
      i_CNT        = 1'b0;
      i_CLR        = 1'b0;
      i_AUTORELOAD = 1'b0;
      i_LIMIT      = '0;
      i_SNAP_LD_n  = 1'b1;
      repeat (3) @(posedge i_MCLK);
      #2;
      check("reset_count",   32'(o_COUNT),      32'd0);
      check("reset_tov_n",   32'(o_TIMEOVER_n), 32'd1);
      check("reset_match",   32'(o_MATCH),      32'd0);
      check("reset_wrap",    32'(o_WRAP),       32'd0);
      i_RST = 1'b0;
      @(posedge i_MCLK); #2;

      // One-shot, LIMIT=20, enable every 2nd MCLK, snapshot every frame.
      i_CNT = 1'b1; i_LIMIT = W'(20); i_AUTORELOAD = 1'b0;
      run_frames(20, 1'b1, 1'b0);
      check("oneshot_count_at_limit", 32'(o_COUNT),      32'd20);
      check("oneshot_tov_low",        32'(o_TIMEOVER_n), 32'd0);
      check("oneshot_first_match",    32'(n_match_seen), 32'd1);
      run_frames(3, 1'b1, 1'b0);
      check("oneshot_hold_count",     32'(o_COUNT),      32'd20);
      check("oneshot_hold_tov",       32'(o_TIMEOVER_n), 32'd0);
      check("oneshot_hold_matches",   32'(n_match_seen), 32'd4);

      // Periodic, LIMIT=4: clear frame, then 0..4 repeating.
      match_base   = n_match_seen;
      i_AUTORELOAD = 1'b1; i_LIMIT = W'(4); i_CLR = 1'b1;
      run_frames(1, 1'b1, 1'b0);
      check("reload_clear_count", 32'(o_COUNT),      32'd0);
      check("reload_clear_tov",   32'(o_TIMEOVER_n), 32'd1);
      i_CLR = 1'b0;
      run_frames(4, 1'b1, 1'b0);
      check("reload_at_limit",    32'(o_COUNT),      32'd4);
      check("reload_tov_low",     32'(o_TIMEOVER_n), 32'd0);
      run_frames(1, 1'b1, 1'b0);
      check("reload_wrote_zero",  32'(o_COUNT),      32'd0);
      check("reload_tov_one_frame", 32'(o_TIMEOVER_n), 32'd1);
      run_frames(10, 1'b1, 1'b0);
      check("reload_end_count",   32'(o_COUNT),      32'd0);
      check("reload_matches",     32'(n_match_seen - match_base), 32'd3);

      // Wrap: one-shot with an unreached limit, count past all-ones.
      match_base   = n_match_seen;
      wrap_base    = n_wrap_seen;
      i_AUTORELOAD = 1'b0; i_LIMIT = W'(200); i_CLR = 1'b1;
      run_frames(1, 1'b1, 1'b0);
      i_CLR = 1'b0;
      run_frames(10, 1'b1, 1'b0);
      check("pre_wrap_count", 32'(o_COUNT), 32'd10);
      i_LIMIT = W'(5);
      run_frames(248, 1'b0, 1'b0);
      check("post_wrap_count",   32'(o_COUNT),                   32'd2);
      check("wrap_pulses",       32'(n_wrap_seen - wrap_base),   32'd1);
      check("wrap_no_match",     32'(n_match_seen - match_base), 32'd0);
      check("wrap_tov_high",     32'(o_TIMEOVER_n),              32'd1);

      // Snapshot request mid-frame: coherent value, then held.
      for (int s = 0; s < W; s++) begin
         i_SNAP_LD_n = (s != 3);
         slot_cycle(1'b1);
      end
      check("snap_mid_frame", 32'(o_COUNT), 32'd3);
      run_frames(1, 1'b1, 1'b1);
      check("snap_holds", 32'(o_COUNT), 32'd3);
      run_frames(1, 1'b1, 1'b1);
      check("snap_holds_on_match", 32'(o_COUNT),      32'd3);
      check("oneshot5_tov",        32'(o_TIMEOVER_n), 32'd0);

      // Clear outside slot 0 is ignored; clear at slot 0 restarts counting.
      for (int s = 0; s < W; s++) begin
         i_CLR       = (s == 3);
         i_SNAP_LD_n = 1'b1;
         slot_cycle(1'b1);
      end
      check("clr_slot3_ignored", 32'(o_TIMEOVER_n), 32'd0);
      for (int s = 0; s < W; s++) begin
         i_CLR       = (s == 0);
         i_SNAP_LD_n = (s != W - 1);
         slot_cycle(1'b1);
      end
      check("clr_count_zero", 32'(o_COUNT),      32'd0);
      check("clr_tov_high",   32'(o_TIMEOVER_n), 32'd1);
      for (int s = 0; s < W; s++) begin
         i_SNAP_LD_n = (s != W - 1);
         slot_cycle(1'b1);
      end
      check("clr_resumes", 32'(o_COUNT), 32'd1);

      // Asynchronous reset in the middle of a frame.
      for (int s = 0; s < 5; s++) begin
         i_SNAP_LD_n = 1'b1;
         slot_cycle(1'b1);
      end
      #1 i_RST = 1'b1;
      #1;
      check("async_rst_count", 32'(o_COUNT),      32'd0);
      check("async_rst_tov",   32'(o_TIMEOVER_n), 32'd1);
      check("async_rst_match", 32'(o_MATCH),      32'd0);
      check("async_rst_wrap",  32'(o_WRAP),       32'd0);
      @(posedge i_MCLK); #2;
      i_RST   = 1'b0;
      i_CEN_n = 1'b0;
      #1;
      check("frame_start_after_reset", 32'(o_FRAME_START), 32'd1);
      @(posedge i_MCLK); #2;

      // Randomized phase.
      for (int i = 0; i < 3000; i++) begin
         i_CEN_n = ($urandom_range(0, 9) < 3);
         i_CNT   = ($urandom_range(0, 3) != 0);
         i_CLR   = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 99) == 0) i_AUTORELOAD = ~i_AUTORELOAD;
         if ($urandom_range(0, 149) == 0) begin
            case ($urandom_range(0, 3))
               0:       i_LIMIT = '0;
               1:       i_LIMIT = '1;
               default: i_LIMIT = W'($urandom_range(1, 12));
            endcase
         end
         i_SNAP_LD_n = ($urandom_range(0, 7) != 0);
         if (i == 1500) begin
            #1 i_RST = 1'b1;
            #1 i_RST = 1'b0;
         end
         @(posedge i_MCLK); #2;
      end

      i_CEN_n = 1'b1;
      @(posedge i_MCLK); #2;
      @(posedge i_MCLK); #2;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
